spi_slave_if: RTL and testbench



---
 rtl/spi_slave_if.sv | 106 ++++++++++
 tb/tb_spi_slave_if.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave front end, oversampled in the clk domain
//   clk       peripheral clock
//   rst_n     asynchronous active-low reset
//   sclk      SPI serial clock (async, idles low)
//   cs_n      SPI chip select, active low (async)
//   mosi      SPI master-out data
//   miso      SPI master-in data, always driven
//   byte_sync one-cycle pulse when data_in holds a new byte
//   data_in   last fully received byte
//   data_out  response byte shifted out during the following byte
module spi_slave_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       byte_sync,
    output logic [7:0] data_in,
    input  logic [7:0] data_out
);
    typedef enum logic [1:0] {IDLE, ACTIVE, SYNC, LOAD} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic sclk_d;
    logic [7:0] rx, tx;
    logic [2:0] cnt;
    logic sclk_s, cs_s, mosi_s, rise, fall;
    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s;
        end
    end
    // miso is updated together with tx so it always equals tx[7] outside IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            miso      <= 1'b0;
            byte_sync <= 1'b0;
            data_in   <= 8'h00;
            rx        <= 8'h00;
            tx        <= 8'h00;
            cnt       <= 3'd0;
        end else begin
            byte_sync <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= 3'd0;
                    rx   <= 8'h00;
                    tx   <= 8'h00;
                    miso <= 1'b0;
                    if (!cs_s) state <= ACTIVE;
                end
                ACTIVE: begin
                    // chip select has priority over any coincident sclk edge
                    if (cs_s) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                        rx    <= 8'h00;
                        tx    <= 8'h00;
                        miso  <= 1'b0;
                    end else if (rise) begin
                        rx  <= {rx[6:0], mosi_s};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            data_in <= {rx[6:0], mosi_s};
                            state   <= SYNC;
                        end
                    end else if (fall && cnt != 3'd0) begin
                        tx   <= {tx[6:0], 1'b0};
                        miso <= tx[6];
                    end
                end
                SYNC: begin
                    byte_sync <= 1'b1;
                    state     <= cs_s ? IDLE : LOAD;
                    if (cs_s) begin
                        tx   <= 8'h00;
                        miso <= 1'b0;
                    end
                end
                LOAD: begin
                    // decoder read fires on byte_sync, so data_out is valid now
                    state <= cs_s ? IDLE : ACTIVE;
                    tx    <= cs_s ? 8'h00 : data_out;
                    miso  <= cs_s ? 1'b0 : data_out[7];
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: directed self-checking bench for spi_slave_if
module tb_spi_slave_if;
    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, byte_sync;
    logic [7:0] data_in, data_out, dout_const;
    logic use_inv = 1'b0;
    logic bs_prev = 1'b0;
    logic [7:0] q[$];
    logic [7:0] g0, g1, g2, g3, held;
    int total = 0, bad = 0, wide = 0;

    spi_slave_if #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .byte_sync(byte_sync), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // decoder stand-in: either a fixed response or the complement of the last byte
    always_comb data_out = use_inv ? ~data_in : dout_const;

    always @(negedge clk) begin
        if (byte_sync) q.push_back(data_in);
        if (byte_sync && bs_prev) wide++;
        bs_prev <= byte_sync;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int half, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_n(half);
            sclk = 1'b1;
            got[7-i] = miso;
            wait_n(half);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        q.delete();
        cs_n = 1'b0;
        wait_n(4);
    endtask

    task automatic cs_end();
        wait_n(10);
        cs_n = 1'b1;
        wait_n(10);
    endtask

    initial begin
        dout_const = 8'h00;
        wait_n(3);
        chk("rst_miso", miso, 0);
        chk("rst_sync", byte_sync, 0);
        chk("rst_data", data_in, 8'h00);
        rst_n = 1'b1;
        wait_n(3);

        cs_start();
        send_bits(8'h85, 8, 8, g0);
        send_bits(8'h3C, 8, 8, g1);
        cs_end();
        chk("wr_pulses", q.size(), 2);
        chk("wr_b0", q[0], 8'h85);
        chk("wr_b1", q[1], 8'h3C);
        chk("wr_width", wide, 0);
        chk("wr_miso0", g0, 8'h00);

        dout_const = 8'hA5;
        cs_start();
        send_bits(8'h02, 8, 8, g0);
        send_bits(8'h00, 8, 8, g1);
        cs_end();
        chk("rd_first", g0, 8'h00);
        chk("rd_resp", g1, 8'hA5);
        chk("rd_pulses", q.size(), 2);
        chk("rd_b1", q[1], 8'h00);

        dout_const = 8'h00;
        cs_start();
        send_bits(8'hFF, 5, 8, g0);
        cs_n = 1'b1;
        wait_n(10);
        chk("ab_pulses", q.size(), 0);
        chk("ab_miso", miso, 0);
        cs_start();
        send_bits(8'h5A, 8, 8, g0);
        cs_end();
        chk("ab_next_pulses", q.size(), 1);
        chk("ab_next_b0", q[0], 8'h5A);

        q.delete();
        held = data_in;
        mosi = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sclk = ~sclk;
            wait_n(6);
        end
        wait_n(6);
        chk("idle_pulses", q.size(), 0);
        chk("idle_data", data_in, held);
        chk("idle_miso", miso, 0);

        cs_start();
        send_bits(8'hFF, 3, 8, g0);
        rst_n = 1'b0;
        #1;
        chk("mr_data", data_in, 8'h00);
        chk("mr_sync", byte_sync, 0);
        chk("mr_miso", miso, 0);
        cs_n = 1'b1;
        wait_n(2);
        rst_n = 1'b1;
        wait_n(6);
        cs_start();
        send_bits(8'hC3, 8, 8, g0);
        cs_end();
        chk("mr_pulses", q.size(), 1);
        chk("mr_b0", data_in, 8'hC3);

        use_inv = 1'b1;
        wide = 0;
        cs_start();
        send_bits(8'h01, 8, 4, g0);
        send_bits(8'h80, 8, 4, g1);
        send_bits(8'hFF, 8, 4, g2);
        send_bits(8'h00, 8, 4, g3);
        cs_end();
        chk("er_pulses", q.size(), 4);
        chk("er_b0", q[0], 8'h01);
        chk("er_b1", q[1], 8'h80);
        chk("er_b2", q[2], 8'hFF);
        chk("er_b3", q[3], 8'h00);
        chk("er_r0", g0, 8'h00);
        chk("er_r1", g1, 8'hFE);
        chk("er_r2", g2, 8'h7F);
        chk("er_r3", g3, 8'h00);
        chk("er_width", wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
